// File: rtl/io_oc_multi.sv
// Multi-channel I/O operation-control registers: per-channel OC register, one-deep
// pending command, word-time timeout and T0-aligned release toward the device controllers.

module io_oc_chan #(
   parameter int OCW = 4,
   parameter int TMO = 108
) (
   input  logic           CLOCK,
   input  logic           rst,
   input  logic           word_tick,
   input  logic           clr,
   input  logic           done,
   input  logic           stop,
   input  logic           cmd_ld,
   input  logic [OCW-1:0] cmd_op,
   output logic [OCW-1:0] oc,
   output logic           ready,
   output logic           pend_full,
   output logic           timeout
);
   localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

   state_t         state, state_nxt;
   logic [OCW-1:0] oc_nxt, pend_op, pend_op_nxt, next_op;
   logic           pend_vld, pend_vld_nxt, tmo_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           new_cmd, have_next, tmo_hit, rel;

   assign new_cmd   = cmd_ld & (cmd_op != '0);
   // On release a queued op wins; otherwise a command arriving that cycle loads straight in.
   assign have_next = pend_vld | new_cmd;
   assign next_op   = pend_vld ? pend_op : cmd_op;
   assign tmo_hit   = (TMO > 0) && word_tick && (cnt == CW'(TMO - 1));

   always_comb begin
      state_nxt    = state;
      oc_nxt       = oc;
      pend_vld_nxt = pend_vld;
      pend_op_nxt  = pend_op;
      cnt_nxt      = cnt;
      tmo_nxt      = 1'b0;
      rel          = 1'b0;
      if (clr) begin
         state_nxt    = IDLE;
         oc_nxt       = '0;
         pend_vld_nxt = 1'b0;
         cnt_nxt      = '0;
      end else begin
         case (state)
            IDLE: if (new_cmd) begin
               state_nxt = ACTIVE;
               oc_nxt    = cmd_op;
               cnt_nxt   = '0;
            end
            ACTIVE: begin
               if (tmo_hit) begin
                  tmo_nxt = 1'b1;
                  rel     = 1'b1;
               end else if (done | stop) begin
                  state_nxt = DRAIN;
               end else if (word_tick && cnt != CW'(TMO)) begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
            DRAIN:   if (word_tick) rel = 1'b1;
            default: state_nxt = IDLE;
         endcase
         if (rel) begin
            cnt_nxt      = '0;
            pend_vld_nxt = 1'b0;
            if (have_next) begin
               state_nxt = ACTIVE;
               oc_nxt    = next_op;
            end else begin
               state_nxt = IDLE;
               oc_nxt    = '0;
            end
         end else if (state != IDLE && new_cmd && !pend_vld) begin
            pend_vld_nxt = 1'b1;
            pend_op_nxt  = cmd_op;
         end
      end
   end

   always_ff @(posedge CLOCK or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         oc       <= '0;
         pend_vld <= 1'b0;
         pend_op  <= '0;
         cnt      <= '0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_nxt;
         oc       <= oc_nxt;
         pend_vld <= pend_vld_nxt;
         pend_op  <= pend_op_nxt;
         cnt      <= cnt_nxt;
         timeout  <= tmo_nxt;
      end
   end

   assign ready     = (state == IDLE) & ~pend_vld;
   assign pend_full = pend_vld;
endmodule

module io_oc_multi #(
   parameter  int NCH = 2,
   parameter  int OCW = 4,
   parameter  int TMO = 108,
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic               CLOCK,
   input  logic               rst,
   input  logic               word_tick,
   input  logic               cmd_valid,
   input  logic [CHW-1:0]     cmd_ch,
   input  logic [OCW-1:0]     cmd_op,
   output logic               cmd_ready,
   output logic               cmd_err,
   input  logic [NCH-1:0]     clr,
   input  logic [NCH-1:0]     done,
   input  logic [NCH-1:0]     stop,
   output logic [NCH*OCW-1:0] oc,
   output logic [NCH-1:0]     ready,
   output logic               all_ready,
   output logic [NCH-1:0]     timeout,
   output logic [NCH-1:0]     fast_in,
   output logic [NCH-1:0]     fast_out,
   output logic [NCH-1:0]     slow_in,
   output logic [NCH-1:0]     slow_out
);
   localparam int NPAD = 1 << CHW;

   logic [NCH-1:0][OCW-1:0] oc_ch;
   logic [NCH-1:0]          pend_full;
   logic [NPAD-1:0]         blk_pad;
   logic                    acc, in_range;

   // Padded so an out-of-range select reads "not blocked" and the command is swallowed.
   always_comb begin
      blk_pad          = '0;
      blk_pad[NCH-1:0] = pend_full | clr;
   end

   assign cmd_ready = ~blk_pad[cmd_ch];
   assign in_range  = 32'(cmd_ch) < 32'(NCH);
   assign acc       = cmd_valid & cmd_ready;

   always_ff @(posedge CLOCK or negedge rst) begin
      if (!rst) cmd_err <= 1'b0;
      else      cmd_err <= acc & ~in_range;
   end

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic slow, inb, nz;

      io_oc_chan #(.OCW(OCW), .TMO(TMO)) u_ch (
         .CLOCK     (CLOCK),
         .rst       (rst),
         .word_tick (word_tick),
         .clr       (clr[i]),
         .done      (done[i]),
         .stop      (stop[i]),
         .cmd_ld    (acc & in_range & (cmd_ch == CHW'(i))),
         .cmd_op    (cmd_op),
         .oc        (oc_ch[i]),
         .ready     (ready[i]),
         .pend_full (pend_full[i]),
         .timeout   (timeout[i])
      );

      assign nz          = |oc_ch[i];
      assign slow        = oc_ch[i][OCW-1];
      assign inb         = oc_ch[i][OCW-2];
      assign fast_in[i]  = nz &  inb & ~slow;
      assign fast_out[i] = nz & ~inb & ~slow;
      assign slow_in[i]  = nz &  inb &  slow;
      assign slow_out[i] = nz & ~inb &  slow;
   end

   assign oc        = oc_ch;
   assign all_ready = &ready;
endmodule

// File: tb/tb_io_oc_multi.sv
// Directed bench: u_a (defaults), u_c (TMO=0, same stimulus as u_a), u_b (NCH=3, TMO=3).

module tb_io_oc_multi;
   logic CLOCK, rst, word_tick;

   logic       a_cmd_valid, a_cmd_ready, a_cmd_err, a_all_ready;
   logic [0:0] a_cmd_ch;
   logic [3:0] a_cmd_op;
   logic [1:0] a_clr, a_done, a_stop, a_ready, a_timeout;
   logic [1:0] a_fast_in, a_fast_out, a_slow_in, a_slow_out;
   logic [7:0] a_oc;

   logic       c_cmd_ready, c_cmd_err, c_all_ready;
   logic [1:0] c_ready, c_timeout, c_fast_in, c_fast_out, c_slow_in, c_slow_out;
   logic [7:0] c_oc;

   logic        b_cmd_valid, b_cmd_ready, b_cmd_err, b_all_ready;
   logic [1:0]  b_cmd_ch;
   logic [3:0]  b_cmd_op;
   logic [2:0]  b_clr, b_done, b_stop, b_ready, b_timeout;
   logic [2:0]  b_fast_in, b_fast_out, b_slow_in, b_slow_out;
   logic [11:0] b_oc;

   int n_chk = 0;
   int n_err = 0;

   io_oc_multi u_a (
      .CLOCK(CLOCK), .rst(rst), .word_tick(word_tick), .cmd_valid(a_cmd_valid),
      .cmd_ch(a_cmd_ch), .cmd_op(a_cmd_op), .cmd_ready(a_cmd_ready), .cmd_err(a_cmd_err),
      .clr(a_clr), .done(a_done), .stop(a_stop), .oc(a_oc), .ready(a_ready),
      .all_ready(a_all_ready), .timeout(a_timeout), .fast_in(a_fast_in),
      .fast_out(a_fast_out), .slow_in(a_slow_in), .slow_out(a_slow_out));

   io_oc_multi #(.TMO(0)) u_c (
      .CLOCK(CLOCK), .rst(rst), .word_tick(word_tick), .cmd_valid(a_cmd_valid),
      .cmd_ch(a_cmd_ch), .cmd_op(a_cmd_op), .cmd_ready(c_cmd_ready), .cmd_err(c_cmd_err),
      .clr(a_clr), .done(a_done), .stop(a_stop), .oc(c_oc), .ready(c_ready),
      .all_ready(c_all_ready), .timeout(c_timeout), .fast_in(c_fast_in),
      .fast_out(c_fast_out), .slow_in(c_slow_in), .slow_out(c_slow_out));

   io_oc_multi #(.NCH(3), .TMO(3)) u_b (
      .CLOCK(CLOCK), .rst(rst), .word_tick(word_tick), .cmd_valid(b_cmd_valid),
      .cmd_ch(b_cmd_ch), .cmd_op(b_cmd_op), .cmd_ready(b_cmd_ready), .cmd_err(b_cmd_err),
      .clr(b_clr), .done(b_done), .stop(b_stop), .oc(b_oc), .ready(b_ready),
      .all_ready(b_all_ready), .timeout(b_timeout), .fast_in(b_fast_in),
      .fast_out(b_fast_out), .slow_in(b_slow_in), .slow_out(b_slow_out));

   initial begin
      CLOCK = 1'b0;
      forever #5 CLOCK = ~CLOCK;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic a_cmd(input logic ch, input logic [3:0] op);
      a_cmd_valid = 1'b1; a_cmd_ch = ch; a_cmd_op = op;
      tick();
      a_cmd_valid = 1'b0;
   endtask

   task automatic b_cmd(input logic [1:0] ch, input logic [3:0] op);
      b_cmd_valid = 1'b1; b_cmd_ch = ch; b_cmd_op = op;
      tick();
      b_cmd_valid = 1'b0;
   endtask

   task automatic wt();
      word_tick = 1'b1;
      tick();
      word_tick = 1'b0;
   endtask

   initial begin
      int a_to0, a_to1, c_to;
      rst = 1'b0; word_tick = 1'b0;
      a_cmd_valid = 1'b0; a_cmd_ch = '0; a_cmd_op = '0; a_clr = '0; a_done = '0; a_stop = '0;
      b_cmd_valid = 1'b0; b_cmd_ch = '0; b_cmd_op = '0; b_clr = '0; b_done = '0; b_stop = '0;
      repeat (2) tick();
      rst = 1'b1;

      // reset state
      chk("rst_ready", 32'(a_ready), 32'h3);
      chk("rst_all_ready", 32'(a_all_ready), 32'h1);
      chk("rst_oc", 32'(a_oc), 32'h0);
      chk("rst_cmd_ready", 32'(a_cmd_ready), 32'h1);
      chk("rst_b_timeout", 32'(b_timeout), 32'h0);

      // load ch1, latency 1
      a_cmd(1'b1, 4'b1100);
      chk("ld_oc", 32'(a_oc), 32'hC0);
      chk("ld_slow_in", 32'(a_slow_in), 32'h2);
      chk("ld_fast_out", 32'(a_fast_out), 32'h0);
      chk("ld_ready", 32'(a_ready), 32'h1);
      chk("ld_all_ready", 32'(a_all_ready), 32'h0);

      // op 0 is accepted and discarded
      a_cmd_ch = 1'b0;
      chk("nop_cmd_ready", 32'(a_cmd_ready), 32'h1);
      a_cmd(1'b0, 4'b0000);
      chk("nop_ready", 32'(a_ready), 32'h1);

      // done then T0-aligned release
      a_cmd(1'b0, 4'b1001);
      chk("dn_oc", 32'(a_oc), 32'hC9);
      chk("dn_slow_out", 32'(a_slow_out), 32'h1);
      a_done = 2'b01; tick(); a_done = 2'b00;
      for (int i = 0; i < 4; i++) begin
         chk("dn_hold", 32'(a_oc[3:0]), 32'h9);
         tick();
      end
      chk("dn_hold_last", 32'(a_oc[3:0]), 32'h9);
      wt();
      chk("dn_rel_oc", 32'(a_oc[3:0]), 32'h0);
      chk("dn_rel_ready", 32'(a_ready[0]), 32'h1);

      // pending chain, no zero cycle between ops
      a_cmd(1'b0, 4'b1001);
      a_cmd_ch = 1'b0;
      chk("pd_cmd_ready1", 32'(a_cmd_ready), 32'h1);
      a_cmd(1'b0, 4'b0100);
      chk("pd_cmd_ready_full", 32'(a_cmd_ready), 32'h0);
      a_cmd(1'b0, 4'b0011);
      chk("pd_ready", 32'(a_ready[0]), 32'h0);
      a_done = 2'b01; tick(); a_done = 2'b00;
      chk("pd_drain_oc", 32'(a_oc[3:0]), 32'h9);
      wt();
      chk("pd_chain_oc", 32'(a_oc[3:0]), 32'h4);
      chk("pd_fast_in", 32'(a_fast_in), 32'h1);
      chk("pd_cmd_ready2", 32'(a_cmd_ready), 32'h1);
      a_stop = 2'b01; tick(); a_stop = 2'b00;
      wt();
      chk("pd_dropped_oc", 32'(a_oc[3:0]), 32'h0);

      // timeout TMO=3 on u_b ch0
      b_cmd(2'd0, 4'b1001);
      wt(); tick();
      wt(); tick();
      chk("to_before", 32'(b_timeout), 32'h0);
      chk("to_before_oc", 32'(b_oc[3:0]), 32'h9);
      wt();
      chk("to_pulse", 32'(b_timeout), 32'h1);
      chk("to_oc", 32'(b_oc[3:0]), 32'h0);
      chk("to_ready", 32'(b_ready), 32'h7);
      tick();
      chk("to_one_cycle", 32'(b_timeout), 32'h0);

      // TMO=0 never times out; default TMO=108 does, exactly once per channel
      a_cmd(1'b0, 4'b0110);
      a_to0 = 0; a_to1 = 0; c_to = 0;
      for (int i = 0; i < 200; i++) begin
         word_tick = 1'b1;
         tick();
         word_tick = 1'b0;
         a_to0 += int'(a_timeout[0]); a_to1 += int'(a_timeout[1]); c_to += int'(|c_timeout);
         tick();
         a_to0 += int'(a_timeout[0]); a_to1 += int'(a_timeout[1]); c_to += int'(|c_timeout);
      end
      chk("t0_c_no_timeout", 32'(c_to), 32'h0);
      chk("t0_c_oc", 32'(c_oc), 32'hC6);
      chk("t108_a_to0", 32'(a_to0), 32'h1);
      chk("t108_a_to1", 32'(a_to1), 32'h1);
      chk("t108_a_ready", 32'(a_ready), 32'h3);

      // clr beats timeout and done; pend dropped
      b_cmd(2'd1, 4'b1000);
      b_cmd(2'd1, 4'b0100);
      wt(); tick();
      wt(); tick();
      b_cmd_ch = 2'd1; b_clr = 3'b010;
      chk("cl_cmd_ready", 32'(b_cmd_ready), 32'h0);
      word_tick = 1'b1; b_done = 3'b010;
      tick();
      word_tick = 1'b0; b_done = '0; b_clr = '0;
      chk("cl_timeout", 32'(b_timeout), 32'h0);
      chk("cl_oc", 32'(b_oc[7:4]), 32'h0);
      chk("cl_ready", 32'(b_ready), 32'h7);
      tick();
      chk("cl_ready_hold", 32'(b_ready), 32'h7);

      // out-of-range channel
      b_cmd_ch = 2'd3;
      chk("oor_cmd_ready", 32'(b_cmd_ready), 32'h1);
      b_cmd(2'd3, 4'b1111);
      chk("oor_err", 32'(b_cmd_err), 32'h1);
      chk("oor_oc", 32'(b_oc), 32'h0);
      chk("oor_ready", 32'(b_ready), 32'h7);
      tick();
      chk("oor_err_pulse", 32'(b_cmd_err), 32'h0);

      // asynchronous reset mid-ACTIVE with a pending op
      a_cmd(1'b0, 4'b1001);
      a_cmd(1'b0, 4'b0100);
      chk("ar_pre_oc", 32'(a_oc[3:0]), 32'h9);
      #2 rst = 1'b0;
      #1;
      chk("ar_oc", 32'(a_oc), 32'h0);
      chk("ar_ready", 32'(a_ready), 32'h3);
      chk("ar_timeout", 32'(a_timeout), 32'h0);
      chk("ar_cmd_err", 32'(a_cmd_err), 32'h0);
      tick();
      rst = 1'b1;
      tick();
      chk("ar_pend_gone", 32'(a_ready), 32'h3);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
